// File: rtl/plic_gateway_pkg.sv
// Shared types and default sizing for the PLIC gateway array.
// Each source walks IDLE -> PEND -> CLAIMED -> IDLE.
package plic_gw_pkg;

    localparam int IRQ_NUM_DEF     = 32;
    localparam int IRQ_WIDTH_DEF   = $clog2(IRQ_NUM_DEF);
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_WIDTH_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        CLAIMED = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Claim/complete strobe bus from plic_core into the gateway array.
// Master drives the strobes; the gateway array is the slave.
interface plic_gateway_if #(
    parameter int IRQ_WIDTH = 5
) ();

    logic                 clam_i;
    logic [IRQ_WIDTH-1:0] clam_id_i;
    logic                 comp_i;
    logic [IRQ_WIDTH-1:0] comp_id_i;

    modport master (output clam_i, clam_id_i, comp_i, comp_id_i);
    modport slave  (input  clam_i, clam_id_i, comp_i, comp_id_i);

endinterface

// File: rtl/plic_gateway_cell.sv
// One gateway source: synchroniser, edge detector, edge pending counter,
// and the IDLE/PEND/CLAIMED request state machine.
module plic_gateway_cell
    import plic_gw_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_irq,
    input  logic i_tm,
    input  logic i_en,
    input  logic i_claim,
    input  logic i_comp,
    output logic o_ip,
    output logic o_busy,
    output logic o_ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sd;
    logic                   r_rise;
    logic                   r_tm;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_ovf;
    gw_state_e              r_state;

    gw_state_e              w_state_next;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_ovf_next;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_take;
    logic                   w_done;
    logic                   w_tm_chg;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The rise is registered so level and edge sources see the same latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_sd   <= 1'b0;
            r_rise <= 1'b0;
            r_tm   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_sd   <= w_s;
            r_rise <= w_s & ~r_sd;
            r_tm   <= i_tm;
        end
    end

    assign w_rise   = r_rise & i_tm;
    assign w_tm_chg = r_tm ^ i_tm;
    assign w_take   = (r_state == IDLE) & i_en & (i_tm ? ((r_cnt != '0) | w_rise) : r_sd);
    assign w_done   = (r_state == CLAIMED) & i_comp;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take)  w_state_next = PEND;
            PEND:    if (i_claim) w_state_next = CLAIMED;
            CLAIMED: if (i_comp)  w_state_next = IDLE;
            default:              w_state_next = IDLE;
        endcase
    end

    // An overflow rise in the completing cycle wins over the completion clear.
    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (w_tm_chg) begin
            w_cnt_next = '0;
            w_ovf_next = 1'b0;
        end else begin
            if (w_done) w_ovf_next = 1'b0;
            if (i_tm) begin
                if (w_rise && !w_take) begin
                    if (r_cnt == CNT_MAX) w_ovf_next = 1'b1;
                    else                  w_cnt_next = r_cnt + 1'b1;
                end else if (!w_rise && w_take) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign o_ip   = (r_state == PEND);
    assign o_busy = (r_state != IDLE);
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/plic_gateway.sv
// Gateway array in front of plic_core: decodes claim/complete ids to
// per-source strobes and instantiates one cell per source; source 0 is reserved.
module plic_gateway
    import plic_gw_pkg::*;
#(
    parameter int IRQ_NUM     = IRQ_NUM_DEF,
    parameter int IRQ_WIDTH   = IRQ_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic [IRQ_NUM-1:0] tm_i,
    input  logic               en_i,
    plic_gateway_if.slave      bus,
    output logic [IRQ_NUM-1:0] ip_o,
    output logic [IRQ_NUM-1:0] busy_o,
    output logic [IRQ_NUM-1:0] ovf_o
);

    logic [IRQ_NUM-1:1] w_claim_oh;
    logic [IRQ_NUM-1:1] w_comp_oh;
    logic               w_unused;

    assign w_unused  = irq_i[0] ^ tm_i[0];
    assign ip_o[0]   = 1'b0;
    assign busy_o[0] = 1'b0;
    assign ovf_o[0]  = 1'b0;

    for (genvar i = 1; i < IRQ_NUM; i++) begin : g_cell
        assign w_claim_oh[i] = bus.clam_i & (bus.clam_id_i == IRQ_WIDTH'(i));
        assign w_comp_oh[i]  = bus.comp_i & (bus.comp_id_i == IRQ_WIDTH'(i));

        plic_gateway_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_cell (
            .i_clk   (clk_i),
            .i_rst_n (rst_n_i),
            .i_irq   (irq_i[i]),
            .i_tm    (tm_i[i]),
            .i_en    (en_i),
            .i_claim (w_claim_oh[i]),
            .i_comp  (w_comp_oh[i]),
            .o_ip    (ip_o[i]),
            .o_busy  (busy_o[i]),
            .o_ovf   (ovf_o[i])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed scenarios plus random traffic, all checked
// every cycle against a per-source request/counter model with a 3-cycle input delay.
module tb_plic_gateway;

    localparam int N       = 32;
    localparam int CNT_SAT = 7;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic [N-1:0]  tm;
    logic          en;
    logic [N-1:0]  ip;
    logic [N-1:0]  busy;
    logic [N-1:0]  ovf;

    int testsRun;
    int testsFailed;

    plic_gateway_if #(.IRQ_WIDTH(5)) bus ();

    plic_gateway u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .irq_i   (irq),
        .tm_i    (tm),
        .en_i    (en),
        .bus     (bus),
        .ip_o    (ip),
        .busy_o  (busy),
        .ovf_o   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a request is pending or in flight; edge requests queue in a saturating count.
    logic [N-1:0] hist [0:3];
    bit           mPend [N];
    bit           mBusy [N];
    int           mCnt  [N];
    bit           mOvf  [N];
    logic [N-1:0] mTmPrev;

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mPend[i] = 1'b0;
            mBusy[i] = 1'b0;
            mCnt[i]  = 0;
            mOvf[i]  = 1'b0;
        end
        for (int k = 0; k < 4; k++) hist[k] = '0;
        mTmPrev = '0;
    endfunction

    function automatic void modelEdge();
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        lvl  = hist[2];
        rise = hist[2] & ~hist[3] & tm;
        for (int i = 1; i < N; i++) begin
            bit take;
            bit clm;
            bit cmp;
            int nxt;
            take = !mBusy[i] && en && (tm[i] ? (mCnt[i] > 0 || rise[i]) : lvl[i]);
            clm  = bus.clam_i && (int'(bus.clam_id_i) == i) && mPend[i];
            cmp  = bus.comp_i && (int'(bus.comp_id_i) == i) && mBusy[i] && !mPend[i];
            if (tm[i] != mTmPrev[i]) begin
                mCnt[i] = 0;
                mOvf[i] = 1'b0;
            end else begin
                if (cmp) mOvf[i] = 1'b0;
                if (tm[i]) begin
                    nxt = mCnt[i] + int'(rise[i]) - int'(take);
                    if (nxt > CNT_SAT) begin
                        nxt     = CNT_SAT;
                        mOvf[i] = 1'b1;
                    end
                    mCnt[i] = nxt;
                end
            end
            if (take) begin
                mPend[i] = 1'b1;
                mBusy[i] = 1'b1;
            end else if (clm) begin
                mPend[i] = 1'b0;
            end else if (cmp) begin
                mBusy[i] = 1'b0;
            end
        end
        mTmPrev = tm;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelEdge();
    end

    function automatic logic [N-1:0] expIp();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = mPend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] expBusy();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = mBusy[i];
        return v;
    endfunction

    function automatic logic [N-1:0] expOvf();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = mOvf[i];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock; outputs are compared on the falling edge, inputs change right after.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("ip",   ip,   expIp());
        checkOutput("busy", busy, expBusy());
        checkOutput("ovf",  ovf,  expOvf());
    endtask

    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic claimId(input int id);
        bus.clam_i    = 1'b1;
        bus.clam_id_i = 5'(id);
        applyStimulus();
        bus.clam_i    = 1'b0;
    endtask

    task automatic completeId(input int id);
        bus.comp_i    = 1'b1;
        bus.comp_id_i = 5'(id);
        applyStimulus();
        bus.comp_i    = 1'b0;
    endtask

    task automatic pulse(input int src);
        irq[src] = 1'b1;
        applyStimulus();
        irq[src] = 1'b0;
        applyStimulus();
    endtask

    function automatic logic [N-1:0] bitOf(input logic [N-1:0] v, input int idx);
        return {{(N-1){1'b0}}, v[idx]};
    endfunction

    initial begin
        logic [N-1:0] one;
        one         = {{(N-1){1'b0}}, 1'b1};
        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        irq = '0;
        tm  = '0;
        en  = 1'b1;
        bus.clam_i = 1'b0; bus.clam_id_i = '0;
        bus.comp_i = 1'b0; bus.comp_id_i = '0;
        waitCycles(2);
        checkOutput("reset_ip",   ip,   '0);
        checkOutput("reset_busy", busy, '0);
        checkOutput("reset_ovf",  ovf,  '0);
        rst_n = 1'b1;
        waitCycles(2);

        // Level source: 3-cycle latency, claim, complete with line still high re-pends.
        irq[3] = 1'b1;
        waitCycles(3);
        checkOutput("t1_ip3_early", bitOf(ip, 3), '0);
        applyStimulus();
        checkOutput("t1_ip3_k3", bitOf(ip, 3), one);
        claimId(3);
        checkOutput("t1_ip3_claimed",   bitOf(ip, 3),   '0);
        checkOutput("t1_busy3_claimed", bitOf(busy, 3), one);
        completeId(3);
        checkOutput("t1_busy3_done", bitOf(busy, 3), '0);
        applyStimulus();
        checkOutput("t1_ip3_repend", bitOf(ip, 3), one);
        irq[3] = 1'b0;
        waitCycles(4);
        claimId(3);
        completeId(3);
        waitCycles(2);
        checkOutput("t1_ip3_quiet", bitOf(ip, 3), '0);

        // Edge source: three pulses queue three requests.
        tm[5] = 1'b1;
        applyStimulus();
        for (int p = 0; p < 3; p++) pulse(5);
        waitCycles(4);
        checkOutput("t2_ip5", bitOf(ip, 5), one);
        for (int n = 1; n <= 3; n++) begin
            claimId(5);
            completeId(5);
            applyStimulus();
            checkOutput("t2_ip5_again", bitOf(ip, 5), (n < 3) ? one : '0);
        end

        // Edge overflow while claimed, cleared on complete, then 7 queued requests.
        tm[7] = 1'b1;
        applyStimulus();
        pulse(7);
        waitCycles(4);
        claimId(7);
        for (int p = 0; p < 9; p++) pulse(7);
        waitCycles(4);
        checkOutput("t3_ovf7_set", bitOf(ovf, 7), one);
        completeId(7);
        checkOutput("t3_ovf7_clr", bitOf(ovf, 7), '0);
        for (int n = 0; n < 8; n++) begin
            applyStimulus();
            checkOutput("t3_ip7_queue", bitOf(ip, 7), (n < 7) ? one : '0);
            if (n < 7) begin
                claimId(7);
                completeId(7);
            end
        end

        // Global enable gates new requests; claim of id 0 and complete of an idle id are ignored.
        en = 1'b0;
        irq[2] = 1'b1;
        waitCycles(5);
        checkOutput("t4_ip2_gated", bitOf(ip, 2), '0);
        bus.clam_i = 1'b1; bus.clam_id_i = 5'd0;
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd4;
        applyStimulus();
        bus.clam_i = 1'b0;
        bus.comp_i = 1'b0;
        checkOutput("t4_busy_none", busy, '0);
        en = 1'b1;
        applyStimulus();
        checkOutput("t4_ip2_enabled", bitOf(ip, 2), one);
        irq[2] = 1'b0;
        waitCycles(4);
        claimId(2);
        completeId(2);
        applyStimulus();

        // Claim of one id and complete of another in the same cycle.
        irq[3] = 1'b1;
        pulse(5);
        waitCycles(4);
        claimId(5);
        irq[3] = 1'b0;
        bus.clam_i = 1'b1; bus.clam_id_i = 5'd3;
        bus.comp_i = 1'b1; bus.comp_id_i = 5'd5;
        applyStimulus();
        bus.clam_i = 1'b0;
        bus.comp_i = 1'b0;
        checkOutput("t5_busy3", bitOf(busy, 3), one);
        checkOutput("t5_busy5", bitOf(busy, 5), '0);
        waitCycles(4);
        completeId(3);
        waitCycles(4);

        // Asynchronous reset in the middle of a claimed edge request with queued count.
        pulse(7);
        waitCycles(4);
        claimId(7);
        pulse(7);
        pulse(7);
        waitCycles(4);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ip",   ip,   '0);
        checkOutput("t6_rst_busy", busy, '0);
        checkOutput("t6_rst_ovf",  ovf,  '0);
        applyStimulus();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            applyStimulus();
            checkOutput("t6_no_pend", ip, '0);
        end

        // Random traffic on sources 0..7 with occasional trigger-mode flips.
        tm = N'($urandom_range(0, 255)) & 32'h0000_00FE;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [N-1:0] p;
            logic [N-1:0] c;
            int id;
            irq = irq ^ (N'($urandom & $urandom & $urandom) & 32'h0000_00FF);
            en  = ($urandom_range(0, 9) != 0);
            if (cyc % 64 == 63) tm[$urandom_range(1, 7)] ^= 1'b1;
            p  = expIp();
            c  = expBusy() & ~expIp();
            id = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) if (p[k]) id = k;
            end
            bus.clam_i    = ($urandom_range(0, 2) == 0);
            bus.clam_id_i = 5'(id);
            id = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 7; k >= 0; k--) if (c[k]) id = k;
            end
            bus.comp_i    = ($urandom_range(0, 2) == 0);
            bus.comp_id_i = 5'(id);
            applyStimulus();
        end
        bus.clam_i = 1'b0;
        bus.comp_i = 1'b0;
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
